// File: rtl/pipelined_adder_if.sv
// pipelined_adder_if: handshake and operand/result bundle for pipelined_adder.
//
// Parameter: WIDTH - operand and sum width.
// Signals:
//   a, b, cin, sub, in_valid  upstream -> adder   operands, carry-in, subtract mode, valid
//   in_ready                  adder -> upstream   input accepted this cycle
//   sum, cout, out_valid      adder -> downstream result, carry-out, valid
//   out_ready                 downstream -> adder result accepted this cycle
//   ovf                       adder -> downstream signed overflow (only with PIPE_ADD_OVF_EN)
// Modports: master (the side that drives operands and consumes results), slave (the adder).
// Build option: PIPE_ADD_OVF_EN adds the ovf signal.
interface pipelined_adder_if #(
  parameter int unsigned WIDTH = 16
) ();
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             out_valid;
  logic             out_ready;

`ifdef PIPE_ADD_OVF_EN
  logic             ovf;

  modport master (
    output a, b, cin, sub, in_valid, out_ready,
    input  in_ready, sum, cout, out_valid, ovf
  );

  modport slave (
    input  a, b, cin, sub, in_valid, out_ready,
    output in_ready, sum, cout, out_valid, ovf
  );
`else
  modport master (
    output a, b, cin, sub, in_valid, out_ready,
    input  in_ready, sum, cout, out_valid
  );

  modport slave (
    input  a, b, cin, sub, in_valid, out_ready,
    output in_ready, sum, cout, out_valid
  );
`endif
endinterface

// File: rtl/pipelined_adder.sv
// pipelined_adder: pipelined ripple-carry adder/subtractor.
//
// A WIDTH-bit add is split into SEG-bit slices, one slice resolved per pipeline stage. Each stage
// registers the partial sum, the slice carry and the operands (whose upper slices are still
// pending), so one operation can be accepted every cycle. Latency is STAGES = WIDTH/SEG edges
// counting the accept edge; the last stage register drives the outputs directly.
//
// Parameters: WIDTH (multiple of SEG), SEG (1..WIDTH).
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  pipelined_adder_if.slave: a, b, cin, sub, in_valid, in_ready,
//        sum, cout, out_valid, out_ready (+ ovf)
// Build option: PIPE_ADD_OVF_EN adds signed overflow output bus.ovf.
//
// Flow control is a single global enable: the whole pipeline advances when the output register
// is empty or being drained, otherwise every stage holds. Bubbles are not collapsed.
module pipelined_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SEG   = 4
) (
  input logic              clk,
  input logic              rst,
  pipelined_adder_if.slave bus
);

  localparam int unsigned STAGES = WIDTH / SEG;

  // Per-stage state. a_q/b_q hold the full (effective) operands; stage k only reads the slice
  // it resolves, the lower slices are dead once consumed.
  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  a_d   [STAGES];
  logic [WIDTH-1:0]  b_q   [STAGES];
  logic [WIDTH-1:0]  b_d   [STAGES];
  logic [WIDTH-1:0]  sum_q [STAGES];
  logic [WIDTH-1:0]  sum_d [STAGES];
  logic [STAGES-1:0] c_q, c_d;
  logic [STAGES-1:0] v_q, v_d;

  logic              adv;
  logic [WIDTH-1:0]  b_eff;
  logic [SEG:0]      slice_s;

  function automatic logic [SEG:0] slice_add(input logic [SEG-1:0] x,
                                             input logic [SEG-1:0] y,
                                             input logic           c);
    return {1'b0, x} + {1'b0, y} + {{SEG{1'b0}}, c};
  endfunction

  assign adv          = ~v_q[STAGES-1] | bus.out_ready;
  assign bus.in_ready = adv;
  assign b_eff        = bus.b ^ {WIDTH{bus.sub}};

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      a_d[k]   = '0;
      b_d[k]   = '0;
      sum_d[k] = '0;
    end
    c_d     = '0;
    v_d     = '0;
    slice_s = '0;

    // Stage 0 resolves the lowest slice straight from the inputs.
    slice_s           = slice_add(bus.a[SEG-1:0], b_eff[SEG-1:0], bus.cin ^ bus.sub);
    a_d[0]            = bus.a;
    b_d[0]            = b_eff;
    sum_d[0][SEG-1:0] = slice_s[SEG-1:0];
    c_d[0]            = slice_s[SEG];
    v_d[0]            = bus.in_valid;

    for (int k = 1; k < STAGES; k++) begin
      slice_s                = slice_add(a_q[k-1][k*SEG +: SEG], b_q[k-1][k*SEG +: SEG],
                                         c_q[k-1]);
      a_d[k]                 = a_q[k-1];
      b_d[k]                 = b_q[k-1];
      sum_d[k]               = sum_q[k-1];
      sum_d[k][k*SEG +: SEG] = slice_s[SEG-1:0];
      c_d[k]                 = slice_s[SEG];
      v_d[k]                 = v_q[k-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        sum_q[k] <= '0;
      end
      c_q <= '0;
      v_q <= '0;
    end else if (adv) begin
      a_q   <= a_d;
      b_q   <= b_d;
      sum_q <= sum_d;
      c_q   <= c_d;
      v_q   <= v_d;
    end
  end

  assign bus.sum       = sum_q[STAGES-1];
  assign bus.cout      = c_q[STAGES-1];
  assign bus.out_valid = v_q[STAGES-1];

`ifdef PIPE_ADD_OVF_EN
  // Operand MSBs ride along in the last-stage operand registers; all-zero reset gives ovf = 0.
  logic a_msb, b_msb, s_msb;
  assign a_msb   = a_q[STAGES-1][WIDTH-1];
  assign b_msb   = b_q[STAGES-1][WIDTH-1];
  assign s_msb   = sum_q[STAGES-1][WIDTH-1];
  assign bus.ovf = (a_msb == b_msb) & (s_msb != a_msb);
`endif

endmodule
